// File: rtl/sh_ifetch_queue_if.sv
// Bundle of the fetch-queue buses: instruction-memory port, PC redirect, and the
// opcode stream towards decode. The fetch queue takes the master view.
interface sh_ifetch_queue_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_WIDTH  = 32
);
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [MEM_WIDTH-1:0]  mem_rdata;
    logic                  redir_valid;
    logic [ADDR_WIDTH-1:0] redir_pc;
    logic                  out_valid;
    logic [15:0]           out_instr;
    logic [ADDR_WIDTH-1:0] out_pc;
    logic                  out_ready;
    logic                  misalign_err;

    modport master (
        output mem_req, mem_addr, out_valid, out_instr, out_pc, misalign_err,
        input  mem_gnt, mem_rvalid, mem_rdata, redir_valid, redir_pc, out_ready
    );

    modport slave (
        input  mem_req, mem_addr, out_valid, out_instr, out_pc, misalign_err,
        output mem_gnt, mem_rvalid, mem_rdata, redir_valid, redir_pc, out_ready
    );
endinterface

// File: rtl/sh_ifetch_queue.sv
// Instruction-fetch front end: fetches memory words, splits them into big-endian
// 16-bit opcodes and queues them with their PCs; redirects flush and discard stale data.
module sh_ifetch_queue #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    MEM_WIDTH    = 32,
    parameter int                    QUEUE_DEPTH  = 8,
    parameter int                    MAX_OUTST    = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                clk,
    input  logic                n_reset,
    sh_ifetch_queue_if.master   bus
);
    localparam int HW    = MEM_WIDTH / 16;
    localparam int BYTES = MEM_WIDTH / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(HW);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUTST + 1);
    localparam int SUM_W = CNT_W + OUT_W + IDX_W + 4;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_PEND = 1'b1;

    function automatic logic [ADDR_WIDTH-1:0] word_of(input logic [ADDR_WIDTH-1:0] a);
        return {a[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    endfunction

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic                  pend_stale_q, pend_stale_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic [IDX_W-1:0]      skip_idx_q, skip_idx_d;
    logic [OUT_W-1:0]      outst_q, outst_d;
    logic [OUT_W-1:0]      discard_q, discard_d;
    logic [PTR_W-1:0]      rd_q, rd_d;
    logic [PTR_W-1:0]      wr_q, wr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  misalign_q, misalign_d;

    logic [ADDR_WIDTH+15:0] fifo_mem [QUEUE_DEPTH];
    logic [15:0]            lane_instr [HW];
    logic [ADDR_WIDTH-1:0]  lane_pc [HW];

    logic                  redir;
    logic [ADDR_WIDTH-1:0] redir_pc_a;
    logic                  gnt_fire;
    logic                  rsp;
    logic                  push;
    logic                  pop;
    logic [CNT_W-1:0]      n_push;
    logic [SUM_W-1:0]      need_slots;
    logic                  credit_ok;

    assign redir      = bus.redir_valid;
    assign redir_pc_a = {bus.redir_pc[ADDR_WIDTH-1:1], 1'b0};
    assign gnt_fire   = (state_q == S_PEND) && bus.mem_gnt;
    assign rsp        = bus.mem_rvalid;
    assign push       = rsp && (discard_q == '0) && !redir;
    assign pop        = (count_q != '0) && bus.out_ready && !redir;
    assign n_push     = push ? (CNT_W'(HW) - CNT_W'(skip_idx_q)) : '0;

    // Reserve room for every response that could still land, so responses never stall.
    assign need_slots = SUM_W'(count_q) + SUM_W'(HW) * (SUM_W'(outst_q) + SUM_W'(1));
    assign credit_ok  = (SUM_W'(outst_q) < SUM_W'(MAX_OUTST)) &&
                        (need_slots <= SUM_W'(QUEUE_DEPTH));

    genvar gi;
    generate
        for (gi = 0; gi < HW; gi++) begin : g_lane
            assign lane_instr[gi] = bus.mem_rdata[MEM_WIDTH-1-16*gi -: 16];
            assign lane_pc[gi]    = resp_pc_q + ADDR_WIDTH'(2 * gi);
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        pend_stale_d = pend_stale_q;
        fetch_pc_d   = fetch_pc_q;
        resp_pc_d    = resp_pc_q;
        skip_idx_d   = skip_idx_q;
        outst_d      = outst_q + OUT_W'(gnt_fire) - OUT_W'(rsp);
        discard_d    = discard_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        count_d      = count_q;
        misalign_d   = redir && bus.redir_pc[0];

        case (state_q)
            S_IDLE: begin
                if (!redir && credit_ok) begin
                    state_d      = S_PEND;
                    req_addr_d   = word_of(fetch_pc_q);
                    pend_stale_d = 1'b0;
                end
            end
            default: begin
                if (bus.mem_gnt) begin
                    state_d = S_IDLE;
                end
            end
        endcase

        // A held request issued before a redirect must not move fetch_pc when granted.
        if (redir) begin
            pend_stale_d = 1'b1;
            fetch_pc_d   = redir_pc_a;
        end else if (gnt_fire && !pend_stale_q) begin
            fetch_pc_d = req_addr_q + ADDR_WIDTH'(BYTES);
        end

        if (redir) begin
            discard_d = outst_q + OUT_W'(state_q == S_PEND) - OUT_W'(rsp);
        end else if (rsp && (discard_q != '0)) begin
            discard_d = discard_q - OUT_W'(1);
        end

        if (redir) begin
            resp_pc_d  = word_of(redir_pc_a);
            skip_idx_d = redir_pc_a[OFF_W-1:1];
        end else if (push) begin
            resp_pc_d  = resp_pc_q + ADDR_WIDTH'(BYTES);
            skip_idx_d = '0;
        end

        if (redir) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            rd_d    = rd_q + PTR_W'(pop);
            wr_d    = wr_q + PTR_W'(n_push);
            count_d = count_q + n_push - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q      <= S_IDLE;
            req_addr_q   <= word_of(RESET_VECTOR);
            pend_stale_q <= 1'b0;
            fetch_pc_q   <= RESET_VECTOR;
            resp_pc_q    <= word_of(RESET_VECTOR);
            skip_idx_q   <= RESET_VECTOR[OFF_W-1:1];
            outst_q      <= '0;
            discard_q    <= '0;
            rd_q         <= '0;
            wr_q         <= '0;
            count_q      <= '0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_addr_q   <= req_addr_d;
            pend_stale_q <= pend_stale_d;
            fetch_pc_q   <= fetch_pc_d;
            resp_pc_q    <= resp_pc_d;
            skip_idx_q   <= skip_idx_d;
            outst_q      <= outst_d;
            discard_q    <= discard_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            count_q      <= count_d;
            misalign_q   <= misalign_d;
        end
    end

    // Kept halfwords are contiguous from skip_idx_q upward, so they pack densely at wr_q.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = 0; i < HW; i++) begin
                if (i >= int'(skip_idx_q)) begin
                    fifo_mem[wr_q + PTR_W'(i) - PTR_W'(skip_idx_q)] <= {lane_pc[i], lane_instr[i]};
                end
            end
        end
    end

    assign bus.mem_req      = (state_q == S_PEND);
    assign bus.mem_addr     = req_addr_q;
    assign bus.out_valid    = (count_q != '0);
    assign bus.out_instr    = (count_q != '0) ? fifo_mem[rd_q][15:0] : 16'h0;
    assign bus.out_pc       = (count_q != '0) ? fifo_mem[rd_q][ADDR_WIDTH+15:16] : '0;
    assign bus.misalign_err = misalign_q;
endmodule

// File: tb/tb_sh_ifetch_queue.sv
// Randomized bench for sh_ifetch_queue: a memory responder plus a sequential-PC
// reference model of the expected opcode stream (restarts at each redirect target).
module tb_sh_ifetch_queue;
    localparam int AW = 32;
    localparam int MW = 32;
    localparam int QD = 8;
    localparam int MO = 2;
    localparam int HW = MW / 16;

    logic clk = 1'b0;
    logic n_reset = 1'b0;

    sh_ifetch_queue_if #(.ADDR_WIDTH(AW), .MEM_WIDTH(MW)) bus ();

    sh_ifetch_queue #(
        .ADDR_WIDTH(AW), .MEM_WIDTH(MW), .QUEUE_DEPTH(QD),
        .MAX_OUTST(MO), .RESET_VECTOR('0)
    ) dut (
        .clk(clk), .n_reset(n_reset), .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory image: a few fixed opcodes at the bottom, an address hash elsewhere.
    function automatic logic [15:0] hw_at(input logic [AW-1:0] a);
        if (a == 32'h0 || a == 32'h2) return 16'h0009;
        if (a == 32'h4) return 16'hE001;
        if (a == 32'h6) return 16'hE102;
        return a[16:1] ^ a[31:16] ^ 16'h3C5A;
    endfunction

    function automatic logic [MW-1:0] word_at(input logic [AW-1:0] a);
        logic [MW-1:0] w;
        for (int i = 0; i < HW; i++) w[MW-1-16*i -: 16] = hw_at(a + AW'(2 * i));
        return w;
    endfunction

    logic [AW-1:0] rsp_addr[$];
    int            rsp_due[$];
    int            pop_log[$];
    int            cyc = 0;
    int            gnt_pct = 100;
    int            dly_min = 0;
    int            dly_max = 0;
    bit            rdy_rand = 0;
    logic          rdy_fixed = 1'b1;
    bit            redir_go = 0;
    logic [AW-1:0] redir_tgt = '0;
    logic [AW-1:0] exp_pc = '0;
    logic [AW-1:0] last_pop_pc = '1;
    bit            exp_mis = 0;
    bit            exp_flush = 0;
    bit            prev_hold = 0;
    logic [AW-1:0] prev_addr = '0;
    int            pops = 0;

    // One clock cycle: check outputs, drive inputs, update the reference model.
    task automatic step();
        bit            rv;
        bit            do_pop;
        logic [AW-1:0] a;
        @(negedge clk);
        check_eq("misalign_err", bus.misalign_err, exp_mis);
        if (exp_flush) check_eq("flush_out_valid", bus.out_valid, 1'b0);
        if (prev_hold) begin
            check_eq("req_held", bus.mem_req, 1'b1);
            check_eq("addr_held", bus.mem_addr, prev_addr);
        end
        bus.out_ready   = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fixed;
        bus.redir_valid = redir_go;
        bus.redir_pc    = redir_tgt;
        bus.mem_gnt     = (int'($urandom_range(0, 99)) < gnt_pct);
        rv = (rsp_addr.size() != 0) && (rsp_due[0] <= cyc);
        bus.mem_rvalid = rv;
        if (rv) begin
            a = rsp_addr.pop_front();
            void'(rsp_due.pop_front());
            bus.mem_rdata = word_at(a);
        end else begin
            bus.mem_rdata = MW'($urandom);
        end
        if (bus.mem_req && bus.mem_gnt) begin
            check_eq("outst_limit", 64'((rsp_addr.size() + (rv ? 1 : 0)) < MO), 64'd1);
            check_eq("addr_align", bus.mem_addr[1:0], 2'b00);
            rsp_addr.push_back(bus.mem_addr);
            rsp_due.push_back(cyc + 1 + dly_min + int'($urandom_range(0, dly_max)));
        end
        do_pop = bus.out_valid && bus.out_ready && !redir_go;
        if (do_pop) begin
            check_eq("out_pc", bus.out_pc, exp_pc);
            check_eq("out_instr", bus.out_instr, hw_at(exp_pc));
            last_pop_pc = bus.out_pc;
            exp_pc = exp_pc + AW'(2);
            pops++;
            pop_log.push_back(cyc);
        end
        exp_flush = redir_go;
        exp_mis   = redir_go && redir_tgt[0];
        if (redir_go) exp_pc = {redir_tgt[AW-1:1], 1'b0};
        redir_go  = 0;
        prev_hold = bus.mem_req && !bus.mem_gnt;
        prev_addr = bus.mem_addr;
        cyc++;
    endtask

    task automatic redirect_and_expect(input string tag, input logic [AW-1:0] tgt,
                                       input logic [AW-1:0] first_pc);
        int n0;
        redir_go    = 1;
        redir_tgt   = tgt;
        last_pop_pc = '1;
        step();
        n0 = pops;
        for (int i = 0; i < 60 && pops == n0; i++) step();
        check_eq(tag, last_pop_pc, first_pc);
    endtask

    initial begin
        int  n0;
        bit  found;
        bus.out_ready   = 1'b0;
        bus.redir_valid = 1'b0;
        bus.redir_pc    = '0;
        bus.mem_gnt     = 1'b0;
        bus.mem_rvalid  = 1'b0;
        bus.mem_rdata   = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_mem_req", bus.mem_req, 1'b0);
        check_eq("rst_mem_addr", bus.mem_addr, 32'h0);
        check_eq("rst_out_valid", bus.out_valid, 1'b0);
        check_eq("rst_out_instr", bus.out_instr, 16'h0);
        check_eq("rst_out_pc", bus.out_pc, 32'h0);
        check_eq("rst_misalign", bus.misalign_err, 1'b0);
        n_reset = 1'b1;

        // Zero-wait memory, decode always ready: first opcode two cycles after first grant.
        repeat (12) step();
        check_eq("t1_pop_count", 64'(pop_log.size() >= 4), 64'd1);
        if (pop_log.size() >= 4) begin
            check_eq("t1_first_pop_cycle", 64'(pop_log[0]), 64'd2);
            for (int k = 1; k < 4; k++) check_eq("t1_back_to_back", 64'(pop_log[k]), 64'(pop_log[0] + k));
        end

        // Decode stall: queue fills to exactly QD and fetching stops.
        rdy_fixed = 1'b0;
        repeat (20) step();
        check_eq("t2_full_valid", bus.out_valid, 1'b1);
        check_eq("t2_no_req", bus.mem_req, 1'b0);
        check_eq("t2_no_outst", 64'(rsp_addr.size()), 64'd0);
        gnt_pct = 0;
        rdy_fixed = 1'b1;
        n0 = pops;
        repeat (15) step();
        check_eq("t2_held_entries", 64'(pops - n0), 64'(QD));
        gnt_pct = 100;
        repeat (10) step();

        // Redirect with two responses in flight.
        dly_min = 3;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (rsp_addr.size() == 2) found = 1;
        end
        check_eq("t3_two_outst", found, 1'b1);
        redirect_and_expect("t3_first_pc", 32'h102, 32'h102);
        dly_min = 0;

        // Grant withheld for five cycles with a redirect landing mid-wait.
        gnt_pct = 0;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            if (bus.mem_req) found = 1;
        end
        check_eq("t4_req_seen", found, 1'b1);
        repeat (2) step();
        redir_go  = 1;
        redir_tgt = 32'h300;
        last_pop_pc = '1;
        step();
        repeat (2) step();
        gnt_pct = 100;
        n0 = pops;
        for (int i = 0; i < 60 && pops == n0; i++) step();
        check_eq("t4_first_pc", last_pop_pc, 32'h300);

        // Odd redirect target: pulse plus aligned resume.
        redirect_and_expect("t5_first_pc", 32'h201, 32'h200);

        // Address wrap at the top of the space.
        redirect_and_expect("wrap_first_pc", 32'hFFFF_FFFA, 32'hFFFF_FFFA);
        repeat (20) step();

        // Random grants, latencies, decode stalls and redirects (some back to back).
        rdy_rand = 1;
        gnt_pct  = 60;
        dly_max  = 3;
        n0 = pops;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                redir_go  = 1;
                redir_tgt = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom & 32'h0000_0FFF);
            end
            step();
        end
        check_eq("rand_progress", 64'((pops - n0) > 300), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
